// File: rtl/cpu24_pkg.sv
// cpu24_pkg: shared width and state encoding for the sequential multiplier
package cpu24_pkg;
    localparam int WIDTH = 24;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} shumezuesi_state_t;
endpackage

// File: rtl/shumezuesi_sekuencial_if.sv
// shumezuesi_sekuencial_if: request/result bundle between control unit and multiplier
// Start/A/B flow master->slave; Busy/Done/Produkti/Overflow flow slave->master.
interface shumezuesi_sekuencial_if #(parameter int WIDTH = cpu24_pkg::WIDTH);
    logic               Start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               Busy;
    logic               Done;
    logic [2*WIDTH-1:0] Produkti;
    logic               Overflow;
    modport master (output Start, A, B, input Busy, Done, Produkti, Overflow);
    modport slave (input Start, A, B, output Busy, Done, Produkti, Overflow);
endinterface

// File: rtl/Mbledhesi_1b.sv
// Mbledhesi_1b: 1-bit full-adder cell
// Ports: A, B, CIN addends in; Shuma sum out; COUT carry out.
module Mbledhesi_1b (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic Shuma,
    output logic COUT
);
    assign Shuma = A ^ B ^ CIN;
    assign COUT  = (A & B) | (CIN & (A ^ B));
endmodule

// File: rtl/mbledhesi_nb.sv
// mbledhesi_nb: WIDTH-bit ripple-carry adder chained from Mbledhesi_1b cells
// Ports: A, B addends; CIN carry in; Shuma WIDTH-bit sum; COUT final carry.
module mbledhesi_nb #(parameter int WIDTH = cpu24_pkg::WIDTH) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] Shuma,
    output logic             COUT
);
    logic [WIDTH:0] c;
    assign c[0] = CIN;
    assign COUT = c[WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        Mbledhesi_1b u_fa (.A(A[i]), .B(B[i]), .CIN(c[i]), .Shuma(Shuma[i]), .COUT(c[i+1]));
    end
endmodule

// File: rtl/shumezuesi_sekuencial.sv
// shumezuesi_sekuencial: radix-2 shift-and-add unsigned multiplier, WIDTH+1 edge latency
// Ports: Clock, Reset (sync, active-high); bus.slave carries Start/A/B in and
// Busy/Done/Produkti/Overflow out, all outputs registered.
module shumezuesi_sekuencial #(parameter int WIDTH = cpu24_pkg::WIDTH) (
    input  logic                   Clock,
    input  logic                   Reset,
    shumezuesi_sekuencial_if.slave bus
);
    import cpu24_pkg::*;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    shumezuesi_state_t  state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mc_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod_q;
    logic               busy_q, done_q, ovf_q;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    mbledhesi_nb #(.WIDTH(WIDTH)) u_add (
        .A(acc_q[2*WIDTH-1:WIDTH]),
        .B(acc_q[0] ? mc_q : '0),
        .CIN(1'b0),
        .Shuma(sum),
        .COUT(cout)
    );
    // Carry lands in the top bit after the right shift, so nothing is lost.
    assign acc_d = {cout, sum, acc_q[WIDTH-1:1]};
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        prod_q  <= acc_d;
                        ovf_q   <= |acc_d[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        mc_q    <= bus.A;
                        acc_q   <= {{WIDTH{1'b0}}, bus.B};
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Produkti = prod_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_shumezuesi_sekuencial.sv
// tb_shumezuesi_sekuencial: directed self-checking bench for the 24-bit sequential multiplier
module tb_shumezuesi_sekuencial;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    shumezuesi_sekuencial_if #(.WIDTH(24)) bus ();
    shumezuesi_sekuencial #(.WIDTH(24)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
    always #5 Clock = ~Clock;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic run(input string tag, input logic [23:0] a, input logic [23:0] b,
                       input logic [47:0] p, input logic o);
        int n;
        bus.Start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge Clock);
        @(negedge Clock);
        bus.Start = 1'b0;
        n = 1;
        chk({tag, "_busy"}, 64'(bus.Busy), 64'd1);
        while (!bus.Done && n < 40) begin
            @(posedge Clock);
            n++;
            @(negedge Clock);
        end
        chk({tag, "_lat"}, 64'(n), 64'd25);
        chk({tag, "_prod"}, 64'(bus.Produkti), 64'(p));
        chk({tag, "_ovf"}, 64'(bus.Overflow), 64'(o));
        @(negedge Clock);
        chk({tag, "_done_low"}, 64'(bus.Done), 64'd0);
        chk({tag, "_busy_low"}, 64'(bus.Busy), 64'd0);
        chk({tag, "_prod_hold"}, 64'(bus.Produkti), 64'(p));
    endtask
    initial begin
        int n, dones, last;
        bit prev;
        bus.Start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(negedge Clock);
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_prod", 64'(bus.Produkti), 64'd0);
        chk("rst_ovf", 64'(bus.Overflow), 64'd0);
        Reset = 1'b0;
        @(negedge Clock);
        run("m3x5", 24'd3, 24'd5, 48'd15, 1'b0);
        run("mmax", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1);
        run("m0", 24'h000000, 24'h123456, 48'd0, 1'b0);
        run("mmsb", 24'h800000, 24'd2, 48'h1000000, 1'b1);
        // Start pulse mid-CALC with different operands must be ignored.
        bus.Start = 1'b1;
        bus.A = 24'd7;
        bus.B = 24'd6;
        @(posedge Clock);
        @(negedge Clock);
        bus.Start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(posedge Clock);
            n++;
            @(negedge Clock);
        end
        bus.Start = 1'b1;
        bus.A = 24'd9;
        bus.B = 24'd9;
        @(posedge Clock);
        n++;
        @(negedge Clock);
        bus.Start = 1'b0;
        while (!bus.Done && n < 40) begin
            @(posedge Clock);
            n++;
            @(negedge Clock);
        end
        chk("ign_lat", 64'(n), 64'd25);
        chk("ign_prod", 64'(bus.Produkti), 64'd42);
        @(negedge Clock);
        chk("ign_idle", 64'(bus.Busy), 64'd0);
        // Reset in the middle of an operation.
        bus.Start = 1'b1;
        bus.A = 24'd100;
        bus.B = 24'd100;
        @(posedge Clock);
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (11) @(negedge Clock);
        Reset = 1'b1;
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        Reset = 1'b0;
        chk("mrst_busy", 64'(bus.Busy), 64'd0);
        chk("mrst_done", 64'(bus.Done), 64'd0);
        chk("mrst_prod", 64'(bus.Produkti), 64'd0);
        chk("mrst_ovf", 64'(bus.Overflow), 64'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (bus.Done || bus.Busy) dones++;
        end
        chk("mrst_no_done", 64'(dones), 64'd0);
        run("m2x3", 24'd2, 24'd3, 48'd6, 1'b0);
        // Start held high: back-to-back operations, no idle cycle.
        bus.Start = 1'b1;
        bus.A = 24'd4;
        bus.B = 24'd5;
        dones = 0;
        last = 0;
        prev = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (prev) chk("b2b_busy", 64'(bus.Busy), 64'd1);
            prev = bus.Done;
            if (bus.Done) begin
                dones++;
                chk("b2b_gap", 64'(c - last), 64'd25);
                chk("b2b_prod", 64'(bus.Produkti), 64'd20);
                last = c;
            end
        end
        chk("b2b_count", 64'(dones), 64'd3);
        bus.Start = 1'b0;
        n = 0;
        while (!bus.Done && n < 40) begin
            @(posedge Clock);
            n++;
            @(negedge Clock);
        end
        chk("b2b_tail_prod", 64'(bus.Produkti), 64'd20);
        @(negedge Clock);
        chk("b2b_tail_idle", 64'(bus.Busy), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
